// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared state encoding and channel-count derivation
package mux_scan_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
  localparam int LOG_WIDTH_DEF = 4;
  function automatic int num_ch(input int log_width);
    return 1 << log_width;
  endfunction
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: control, mux and result handshake signals of the scan sequencer
interface mux_scan_sequencer_if import mux_scan_sequencer_pkg::*; #(
  parameter int LOG_WIDTH = LOG_WIDTH_DEF
);
  localparam int NUM_CH = num_ch(LOG_WIDTH);
  logic start_i;
  logic abort_i;
  logic continuous_i;
  logic [LOG_WIDTH-1:0] first_i;
  logic [LOG_WIDTH-1:0] last_i;
  logic bit_i;
  logic [LOG_WIDTH-1:0] sel_o;
  logic busy_o;
  logic [NUM_CH-1:0] result_o;
  logic result_valid_o;
  logic result_ready_i;
  modport master (
    input start_i, abort_i, continuous_i, first_i, last_i, bit_i, result_ready_i,
    output sel_o, busy_o, result_o, result_valid_o
  );
  modport slave (
    output start_i, abort_i, continuous_i, first_i, last_i, bit_i, result_ready_i,
    input sel_o, busy_o, result_o, result_valid_o
  );
endinterface

// File: rtl/mux_scan_sequencer_bit_sync.sv
// mux_scan_sequencer_bit_sync: reset-to-zero flop chain bringing the async mux output into clk
module mux_scan_sequencer_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = STAGES'({sync_q, d});
  // shift the raw bit one stage deeper every cycle
  always_ff @(posedge clk)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the mux select over a channel range and assembles a snapshot word
module mux_scan_sequencer import mux_scan_sequencer_pkg::*; #(
  parameter int LOG_WIDTH   = LOG_WIDTH_DEF,
  parameter int SETTLE_CYC  = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  mux_scan_sequencer_if.master bus
);
  localparam int NUM_CH = num_ch(LOG_WIDTH);
  state_e state_q, state_d;
  logic [LOG_WIDTH-1:0] sel_q, sel_d, first_q, first_d, last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] work_q, work_d, result_q, result_d;
  logic valid_q, valid_d, bit_s;
  mux_scan_sequencer_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d(bus.bit_i),
    .q(bit_s)
  );
  // next-state and datapath; abort overrides start and sample completion
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    first_d = first_q;
    last_d = last_q;
    cnt_d = cnt_q;
    work_d = work_q;
    result_d = result_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        first_d = bus.first_i;
        last_d = bus.last_i;
        sel_d = bus.first_i;
        work_d = '0;
        cnt_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        state_d = cnt_q == 4'(SETTLE_CYC - 1) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        work_d[sel_q] = bit_s;
        if (sel_q == last_q) begin
          result_d = work_d;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          sel_d = sel_q + 1'b1;
          cnt_d = '0;
          state_d = SETTLE;
        end
      end
      DONE: if (bus.result_ready_i) begin
        valid_d = 1'b0;
        state_d = bus.continuous_i ? SETTLE : IDLE;
        sel_d = bus.continuous_i ? first_q : sel_q;
        cnt_d = '0;
        work_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) begin
      state_d = IDLE;
      sel_d = sel_q;
      cnt_d = cnt_q;
      work_d = work_q;
      result_d = result_q;
      valid_d = 1'b0;
    end
  end
  // state and datapath registers
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q <= '0;
      first_q <= '0;
      last_q <= '0;
      cnt_q <= '0;
      work_q <= '0;
      result_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      first_q <= first_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      work_q <= work_d;
      result_q <= result_d;
      valid_q <= valid_d;
    end
  assign bus.sel_o = sel_q;
  assign bus.busy_o = state_q == SETTLE || state_q == SAMPLE;
  assign bus.result_o = result_q;
  assign bus.result_valid_o = valid_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: table-driven scans with a result scoreboard plus corner-case sequences
module tb_mux_scan_sequencer;
  localparam int SETTLE = 3;
  localparam int PER_CH = SETTLE + 1;
  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    logic [15:0] io;
    logic [15:0] res;
    int lat;
  } vec_t;
  typedef struct {
    logic [15:0] res;
    int lat;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [15:0] io_in = '0;
  logic [15:0] prev_res;
  logic [3:0] sel_seen[$];
  exp_t sb[$];
  vec_t tbl[6];
  int total = 0;
  int bad = 0;
  mux_scan_sequencer_if bus();
  assign bus.bit_i = io_in[bus.sel_o];
  mux_scan_sequencer #(.LOG_WIDTH(4), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int lat, output int busy_n, output bit ok);
    lat = 0;
    busy_n = 0;
    ok = 0;
    while (lat < budget && !ok) begin
      tick();
      bus.start_i = 0;
      lat++;
      if (bus.busy_o) begin
        busy_n++;
        if (sel_seen.size() == 0 || sel_seen[$] != bus.sel_o) sel_seen.push_back(bus.sel_o);
      end
      ok = bus.result_valid_o;
    end
  endtask

  task automatic run_scan(input vec_t v, input bit do_accept);
    exp_t e;
    int lat, busy_n, n;
    bit ok, seq_ok;
    logic [3:0] s;
    tick();
    bus.first_i = v.f;
    bus.last_i = v.l;
    io_in = v.io;
    bus.start_i = 1;
    sb.push_back('{v.res, v.lat});
    sel_seen.delete();
    wait_valid(300, lat, busy_n, ok);
    chk("valid_seen", 32'(ok), 1);
    e = sb.pop_front();
    chk("result", 32'(bus.result_o), 32'(e.res));
    chk("latency", lat, e.lat);
    n = ((int'(v.l) - int'(v.f) + 16) % 16) + 1;
    chk("busy_cycles", busy_n, n * PER_CH);
    seq_ok = sel_seen.size() == n;
    for (int k = 0; k < n && seq_ok; k++) begin
      s = 4'(int'(v.f) + k);
      seq_ok = sel_seen[k] == s;
    end
    chk("sel_seq", 32'(seq_ok), 1);
    prev_res = e.res;
    if (do_accept) begin
      bus.result_ready_i = 1;
      tick();
      bus.result_ready_i = 0;
      chk("valid_drop", 32'(bus.result_valid_o), 0);
    end
  endtask

  initial begin
    exp_t e;
    int lat, busy_n, guard;
    bit ok;
    tbl[0] = '{4'd0, 4'd15, 16'hA5C3, 16'hA5C3, 16 * PER_CH + 1};
    tbl[1] = '{4'd14, 4'd1, 16'hFFFF, 16'hC003, 4 * PER_CH + 1};
    tbl[2] = '{4'd7, 4'd7, 16'hFFFF, 16'h0080, PER_CH + 1};
    tbl[3] = '{4'd3, 4'd5, 16'h0028, 16'h0028, 3 * PER_CH + 1};
    tbl[4] = '{4'd15, 4'd0, 16'h8001, 16'h8001, 2 * PER_CH + 1};
    tbl[5] = '{4'd0, 4'd15, 16'h5A3C, 16'h5A3C, 16 * PER_CH + 1};
    bus.start_i = 0;
    bus.abort_i = 0;
    bus.continuous_i = 0;
    bus.first_i = 0;
    bus.last_i = 0;
    bus.result_ready_i = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst_sel", 32'(bus.sel_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_result", 32'(bus.result_o), 0);
    chk("rst_valid", 32'(bus.result_valid_o), 0);
    for (int i = 0; i < 6; i++) run_scan(tbl[i], 1);
    // continuous: result held while ready low, restart uses latched range
    bus.continuous_i = 1;
    run_scan('{4'd2, 4'd4, 16'h001C, 16'h001C, 3 * PER_CH + 1}, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        bus.first_i = 0;
        bus.last_i = 15;
        io_in = 16'hFFF4;
      end
      chk("hold_valid", 32'(bus.result_valid_o), 1);
      chk("hold_result", 32'(bus.result_o), 32'h001C);
    end
    bus.result_ready_i = 1;
    tick();
    bus.result_ready_i = 0;
    chk("cont_valid_drop", 32'(bus.result_valid_o), 0);
    chk("cont_restart_busy", 32'(bus.busy_o), 1);
    chk("cont_restart_sel", 32'(bus.sel_o), 2);
    sb.push_back('{16'h0014, 0});
    wait_valid(100, lat, busy_n, ok);
    chk("cont_valid_seen", 32'(ok), 1);
    e = sb.pop_front();
    chk("cont_result", 32'(bus.result_o), 32'(e.res));
    prev_res = e.res;
    bus.continuous_i = 0;
    bus.result_ready_i = 1;
    tick();
    bus.result_ready_i = 0;
    chk("cont_stop_valid", 32'(bus.result_valid_o), 0);
    tick();
    chk("cont_stop_busy", 32'(bus.busy_o), 0);
    // abort at channel 5 of a full scan
    bus.first_i = 0;
    bus.last_i = 15;
    io_in = 16'hFFFF;
    bus.start_i = 1;
    guard = 0;
    do begin
      tick();
      bus.start_i = 0;
      guard++;
    end while (!(bus.busy_o && bus.sel_o == 5) && guard < 100);
    chk("abort_reach_ch5", 32'(bus.sel_o), 5);
    bus.abort_i = 1;
    tick();
    bus.abort_i = 0;
    chk("abort_busy", 32'(bus.busy_o), 0);
    chk("abort_valid", 32'(bus.result_valid_o), 0);
    chk("abort_result_kept", 32'(bus.result_o), 32'(prev_res));
    repeat (SETTLE + 3) tick();
    chk("abort_idle_valid", 32'(bus.result_valid_o), 0);
    chk("abort_idle_busy", 32'(bus.busy_o), 0);
    // abort while a result waits in DONE
    run_scan('{4'd7, 4'd7, 16'hFFFF, 16'h0080, PER_CH + 1}, 0);
    bus.abort_i = 1;
    tick();
    bus.abort_i = 0;
    chk("abort_done_valid", 32'(bus.result_valid_o), 0);
    chk("abort_done_busy", 32'(bus.busy_o), 0);
    // reset mid-SETTLE with start held
    bus.first_i = 5;
    bus.last_i = 9;
    io_in = 16'h1234;
    bus.start_i = 1;
    tick();
    bus.start_i = 0;
    tick();
    rst = 1;
    bus.start_i = 1;
    tick();
    chk("midrst_sel", 32'(bus.sel_o), 0);
    chk("midrst_busy", 32'(bus.busy_o), 0);
    chk("midrst_result", 32'(bus.result_o), 0);
    chk("midrst_valid", 32'(bus.result_valid_o), 0);
    rst = 0;
    bus.start_i = 0;
    run_scan('{4'd3, 4'd6, 16'h0048, 16'h0048, 4 * PER_CH + 1}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
